// File: rtl/chacha_qr_core.sv
// chacha_qr_core
// Iterative ChaCha20 quarter-round engine. An operand (a,b,c,d) is accepted
// over a valid/ready handshake, one ARX step is applied per clock for
// 4*REPEAT clocks, and the result is held on a valid/ready output until the
// downstream consumes it.
//
// Ports:
//   clk                 system clock, all state changes on the rising edge
//   rst                 synchronous active-high reset
//   in_valid/in_ready   operand handshake (in_ready high only while idle)
//   in_a..in_d          operand words
//   out_valid/out_ready result handshake (out_valid high only while done)
//   out_a..out_d        result words, driven straight from the state registers
//   busy                high while the ARX steps are running
module chacha_qr_core #(
  parameter int REPEAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  input  logic [31:0] in_c,
  input  logic [31:0] in_d,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_a,
  output logic [31:0] out_b,
  output logic [31:0] out_c,
  output logic [31:0] out_d,
  output logic        busy
);

  localparam int STEPS = 4 * REPEAT;
  // The low two counter bits select the step, so the counter never shrinks
  // below two bits even when a single quarter-round is configured.
  localparam int CW = ($clog2(STEPS) < 2) ? 2 : $clog2(STEPS);
  localparam logic [CW-1:0] LAST_STEP = CW'(STEPS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state, state_next;
  logic [CW-1:0] count, count_next;
  logic [31:0]   a, b, c, d;
  logic [31:0]   a_next, b_next, c_next, d_next;

  // Each step either updates (a,d) or (c,b); the XOR uses the freshly summed
  // word from the same step, so sum and mix are formed side by side here.
  logic [31:0] sum_ab, sum_cd, mix_d, mix_b;

  assign sum_ab = a + b;
  assign sum_cd = c + d;
  assign mix_d  = d ^ sum_ab;
  assign mix_b  = b ^ sum_cd;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      count <= '0;
      a     <= '0;
      b     <= '0;
      c     <= '0;
      d     <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
      a     <= a_next;
      b     <= b_next;
      c     <= c_next;
      d     <= d_next;
    end
  end

  always_comb begin
    state_next = state;
    count_next = count;
    a_next     = a;
    b_next     = b;
    c_next     = c;
    d_next     = d;

    case (state)
      IDLE: begin
        if (in_valid) begin
          a_next     = in_a;
          b_next     = in_b;
          c_next     = in_c;
          d_next     = in_d;
          count_next = '0;
          state_next = RUN;
        end
      end

      RUN: begin
        // Rotations are fixed per step, so they are plain bit rewirings.
        case (count[1:0])
          2'd0: begin
            a_next = sum_ab;
            d_next = {mix_d[15:0], mix_d[31:16]};
          end
          2'd1: begin
            c_next = sum_cd;
            b_next = {mix_b[19:0], mix_b[31:20]};
          end
          2'd2: begin
            a_next = sum_ab;
            d_next = {mix_d[23:0], mix_d[31:24]};
          end
          default: begin
            c_next = sum_cd;
            b_next = {mix_b[24:0], mix_b[31:25]};
          end
        endcase
        count_next = count + 1'b1;
        if (count == LAST_STEP) begin
          state_next = DONE;
        end
      end

      DONE: begin
        // No bypass: retiring the result always passes through IDLE first.
        if (out_ready) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign busy      = (state == RUN);
  assign out_valid = (state == DONE);
  assign out_a     = a;
  assign out_b     = b;
  assign out_c     = c;
  assign out_d     = d;

endmodule

// File: tb/tb_chacha_qr_core.sv
// tb_chacha_qr_core
// Testbench for chacha_qr_core. Two instances are exercised: one with a single
// quarter-round and one with two back-to-back quarter-rounds. Expected results
// come from a quarter-round reference function and are queued when an operand
// is issued; per-instance monitors retire them when a result is consumed.
//
// Ports: none (top-level bench).
module tb_chacha_qr_core;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid1, in_valid2;
  logic        out_ready1, out_ready2;
  logic [31:0] in_a, in_b, in_c, in_d;

  logic        in_ready1, out_valid1, busy1;
  logic [31:0] out_a1, out_b1, out_c1, out_d1;
  logic        in_ready2, out_valid2, busy2;
  logic [31:0] out_a2, out_b2, out_c2, out_d2;

  int checks   = 0;
  int failures = 0;

  logic [127:0] q1[$];
  logic [127:0] q2[$];
  logic [127:0] exp1, exp2;

  localparam logic [127:0] RFC_IN  = 128'h11111111_01020304_9b8d6f43_01234567;
  localparam logic [127:0] RFC_OUT = 128'hea2a92f4_cb1cf8ce_4581472e_5881c4bb;

  always #5 clk = ~clk;

  chacha_qr_core #(.REPEAT(1)) dut1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid1), .in_ready(in_ready1),
    .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_d(in_d),
    .out_valid(out_valid1), .out_ready(out_ready1),
    .out_a(out_a1), .out_b(out_b1), .out_c(out_c1), .out_d(out_d1),
    .busy(busy1)
  );

  chacha_qr_core #(.REPEAT(2)) dut2 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid2), .in_ready(in_ready2),
    .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_d(in_d),
    .out_valid(out_valid2), .out_ready(out_ready2),
    .out_a(out_a2), .out_b(out_b2), .out_c(out_c2), .out_d(out_d2),
    .busy(busy2)
  );

  function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  // Reference: the quarter-round exactly as written in RFC 8439, applied
  // 'rounds' times in sequence.
  function automatic logic [127:0] qrModel(input logic [127:0] s, input int rounds);
    logic [31:0] a, b, c, d;
    {a, b, c, d} = s;
    for (int r = 0; r < rounds; r++) begin
      a = a + b; d = d ^ a; d = rotl(d, 16);
      c = c + d; b = b ^ c; b = rotl(b, 12);
      a = a + b; d = d ^ a; d = rotl(d, 8);
      c = c + d; b = b ^ c; b = rotl(b, 7);
    end
    return {a, b, c, d};
  endfunction

  function automatic logic [127:0] randWords();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic outValidOf(input int which);
    return (which == 1) ? out_valid1 : out_valid2;
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] actual,
                             input logic [127:0] required);
    checks++;
    if (actual !== required) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h", name, actual, required);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one operand for exactly one accept edge and queue its expected result.
  task automatic applyStimulus(input int which, input logic [127:0] op,
                               input logic [127:0] expected);
    {in_a, in_b, in_c, in_d} = op;
    if (which == 1) begin
      in_valid1 = 1'b1;
      q1.push_back(expected);
    end else begin
      in_valid2 = 1'b1;
      q2.push_back(expected);
    end
    tick();
    in_valid1 = 1'b0;
    in_valid2 = 1'b0;
  endtask

  task automatic setReady(input int which, input logic v);
    if (which == 1) out_ready1 = v;
    else            out_ready2 = v;
  endtask

  // Full transaction: accept, bounded wait for the result, optional
  // back-pressure, then retire and confirm the handshake closes.
  task automatic runTxn(input int which, input logic [127:0] op,
                        input logic [127:0] expected, input int latency,
                        input int hold, input string tag);
    int n;
    applyStimulus(which, op, expected);
    n = 0;
    while (!outValidOf(which) && n < 200) begin
      tick();
      n++;
    end
    checkOutput({tag, "_latency"}, 128'(n), 128'(latency));
    repeat (hold) tick();
    setReady(which, 1'b1);
    tick();
    setReady(which, 1'b0);
    if (which == 1)
      checkOutput({tag, "_retire"}, 128'({out_valid1, in_ready1}), 128'(2'b01));
    else
      checkOutput({tag, "_retire"}, 128'({out_valid2, in_ready2}), 128'(2'b01));
  endtask

  // Monitors: compare whenever a result is consumed by the handshake.
  always @(negedge clk) begin
    if (!rst && out_valid1 && out_ready1) begin
      if (q1.size() == 0) begin
        checkOutput("r1_unexpected_result", 128'(1), 128'(0));
      end else begin
        exp1 = q1.pop_front();
        checkOutput("r1_result", {out_a1, out_b1, out_c1, out_d1}, exp1);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && out_valid2 && out_ready2) begin
      if (q2.size() == 0) begin
        checkOutput("r2_unexpected_result", 128'(1), 128'(0));
      end else begin
        exp2 = q2.pop_front();
        checkOutput("r2_result", {out_a2, out_b2, out_c2, out_d2}, exp2);
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [127:0] op, snap, held;
    int n, busyCnt;

    rst = 1'b1;
    in_valid1 = 1'b0; in_valid2 = 1'b0;
    out_ready1 = 1'b0; out_ready2 = 1'b0;
    {in_a, in_b, in_c, in_d} = '0;
    repeat (3) tick();

    // Reset state of both instances.
    checkOutput("reset_outs1", {out_a1, out_b1, out_c1, out_d1}, '0);
    checkOutput("reset_flags1", 128'({out_valid1, busy1, in_ready1}), 128'(3'b001));
    checkOutput("reset_outs2", {out_a2, out_b2, out_c2, out_d2}, '0);
    checkOutput("reset_flags2", 128'({out_valid2, busy2, in_ready2}), 128'(3'b001));
    rst = 1'b0;
    tick();

    // RFC 8439 quarter-round test vector.
    runTxn(1, RFC_IN, RFC_OUT, 4, 0, "rfc");

    // Zero operand, with busy counted across the run.
    applyStimulus(1, '0, '0);
    n = 0; busyCnt = 0;
    while (!out_valid1 && n < 200) begin
      if (busy1) busyCnt++;
      tick();
      n++;
    end
    checkOutput("zero_latency", 128'(n), 128'(4));
    checkOutput("zero_busy_cycles", 128'(busyCnt), 128'(4));
    out_ready1 = 1'b1; tick(); out_ready1 = 1'b0;

    // Back-pressure: result must be held steady while out_ready stays low.
    op = randWords();
    applyStimulus(1, op, qrModel(op, 1));
    n = 0;
    while (!out_valid1 && n < 200) begin
      tick();
      n++;
    end
    snap = qrModel(op, 1);
    for (int i = 0; i < 10; i++) begin
      in_valid1 = 1'b1;
      {in_a, in_b, in_c, in_d} = randWords();
      tick();
      checkOutput("bp_hold", {out_a1, out_b1, out_c1, out_d1, 2'b00, out_valid1, in_ready1} >> 4,
                  {snap, 4'b0010} >> 4);
      checkOutput("bp_flags", 128'({out_valid1, in_ready1}), 128'(2'b10));
    end
    in_valid1 = 1'b0;
    out_ready1 = 1'b1; tick(); out_ready1 = 1'b0;
    checkOutput("bp_release", 128'({out_valid1, in_ready1}), 128'(2'b01));

    // in_valid held high with fresh data every cycle: accepts at k and k+6.
    out_ready1 = 1'b1;
    for (int i = 0; i < 12; i++) begin
      held = randWords();
      {in_a, in_b, in_c, in_d} = held;
      in_valid1 = 1'b1;
      if (i == 0 || i == 6) q1.push_back(qrModel(held, 1));
      tick();
      if (i == 5) checkOutput("held_idle_before_second", 128'({in_ready1, out_valid1}), 128'(2'b10));
      if (i == 6) checkOutput("held_second_accept", 128'({busy1, in_ready1}), 128'(2'b10));
    end
    in_valid1 = 1'b0;
    tick();
    out_ready1 = 1'b0;
    checkOutput("held_drained", 128'(q1.size()), 128'(0));

    // Reset after step 2 discards the computation.
    applyStimulus(1, RFC_IN, RFC_OUT);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    q1.delete();
    checkOutput("midrst_outs", {out_a1, out_b1, out_c1, out_d1}, '0);
    checkOutput("midrst_flags", 128'({out_valid1, busy1, in_ready1}), 128'(3'b001));
    runTxn(1, RFC_IN, RFC_OUT, 4, 1, "rfc_after_rst");

    // Two quarter-rounds per operand.
    runTxn(2, RFC_IN, qrModel(RFC_OUT, 1), 8, 1, "r2_rfc");
    for (int i = 0; i < 4; i++) begin
      op = randWords();
      runTxn(2, op, qrModel(op, 2), 8, int'($urandom_range(0, 3)), "r2_rand");
    end

    // Randomized single-round traffic with random back-pressure.
    for (int i = 0; i < 16; i++) begin
      op = randWords();
      runTxn(1, op, qrModel(op, 1), 4, int'($urandom_range(0, 3)), "r1_rand");
    end

    tick();
    checkOutput("queues_drained", 128'(q1.size() + q2.size()), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/chacha_qr_core.md
Name: chacha_qr_core

Overview:
Iterative ChaCha20 quarter-round datapath. Accepts a 4-word (a,b,c,d) 32-bit state over a valid/ready handshake, computes one ARX step per clock, and presents the result on a valid/ready output. It sits directly behind the byte-serial pin loader inside the TinyTapeout top. The loader assembles the 128-bit operand from ui_in/uio_in and drains the result back out through uo_out.

Parameters:
REPEAT, 1, number of back-to-back quarter-rounds applied to the accepted state (1..8); total ARX steps = 4*REPEAT.

Ports:
clk  input  1  system clock; all state changes on rising edge
rst  input  1  reset, synchronous, active-high
in_valid  input  1  upstream presents operand
in_ready  output  1  core can accept operand (high only in IDLE)
in_a  input  32  word a
in_b  input  32  word b
in_c  input  32  word c
in_d  input  32  word d
out_valid  output  1  result held on out_a..out_d
out_ready  input  1  downstream consumes result
out_a  output  32  result a
out_b  output  32  result b
out_c  output  32  result c
out_d  output  32  result d
busy  output  1  high in RUN state

Behaviour:
- States: IDLE, RUN, DONE. Step counter width clog2(4*REPEAT), minimum 2 bits; step index = counter mod 4.
- Reset (rst=1 at an edge): state=IDLE, counter=0, a/b/c/d registers=0. Results: out_valid=0, busy=0, in_ready=1, out_* = 0. Reset overrides any in-progress computation or pending result.
- IDLE: in_ready=1. On an edge with in_valid=1, latch in_a..in_d, clear the counter, go to RUN. in_valid=0 leaves all state unchanged.
- RUN: in_ready=0 and busy=1. Inputs are ignored, including in_valid. Each edge performs one step, all arithmetic mod 2^32, rotates left:
  - step0: a=a+b; d=(d^a')<<<16
  - step1: c=c+d; b=(b^c')<<<12
  - step2: a=a+b; d=(d^a')<<<8
  - step3: c=c+d; b=(b^c')<<<7
  - a' and c' are the newly summed values within the same step.
- RUN continues: the counter increments each step. After step 4*REPEAT-1 completes, go to DONE.
- DONE: out_valid=1 and out_* = registers. Outputs stay stable until the handshake. On an edge with out_ready=1, go to IDLE with out_valid=0 the next cycle. No bypass: a new operand cannot be accepted on the same edge as output retirement.
- Latency: input handshake at edge k gives out_valid high from edge k+4*REPEAT. Minimum initiation interval is 4*REPEAT+2 cycles.
- out_* are driven directly from the state registers. They are only meaningful while out_valid=1 and may change during RUN.
- out_ready may be high before DONE; it has no effect outside DONE.
- Result registers persist in IDLE until the next accept; only out_valid qualifies them.

Test Plan:
- RFC 8439 §2.1.1, REPEAT=1: in a=11111111 b=01020304 c=9b8d6f43 d=01234567 -> out a=ea2a92f4 b=cb1cf8ce c=4581472e d=5881c4bb; out_valid exactly 4 cycles after the accept edge.
- Zero operand: a=b=c=d=0 -> outputs all 0, out_valid after 4 cycles, busy high for exactly 4 cycles.
- Back-pressure: hold out_ready=0 for 10 cycles in DONE -> out_* and out_valid stable, in_ready=0 throughout. Pulse out_ready -> out_valid=0 and in_ready=1 the next cycle.
- in_valid held high continuously with changing data -> only the word present at the IDLE accept edge is used. The next accept occurs 6 cycles after the first, and the data presented during RUN/DONE is ignored.
- Reset mid-RUN: assert rst after step 2 -> next cycle state is IDLE, out_valid=0, in_ready=1, out_*=0. A fresh RFC vector then yields the correct result.
- REPEAT=2 with the RFC input: result equals the REPEAT=1 output fed back through a second REPEAT=1 instance (reference model); out_valid 8 cycles after accept.
